// File: rtl/sbus_mem_responder.sv
// sbus_mem_responder
//   Memory-side responder for the PA/cycle-type interface driven by the MBox
//   PMA logic. Accepts a start strobe and checks address parity and
//   non-existent memory. It then services a quadword-aligned burst from a
//   local word store. The burst starts at PA34..35 and wraps mod 4 within the
//   quadword. Words whose bit in the word-request mask is clear are skipped.
//
//   Optional feature macro: SBUS_MEM_DATA_PAR_EN
//     defined   -> 37-bit store, wr_data_par_h / rd_data_par_h ports,
//                  sticky data_par_err_h on writes with even data parity
//     undefined -> 36-bit store, data_par_err_h tied low
//
//   pa_h[0] is PA35, the least significant address bit, so pa_h read as an
//   unsigned number is the word address.
module sbus_mem_responder #(
  parameter int MEM_WORDS   = 4096, // multiple of 4; PA >= MEM_WORDS is NXM
  parameter int ACC_LATENCY = 2     // >= 1; ack-to-first-data and word-to-word gap
) (
  input  logic        clk_mem_h,
  input  logic        mem_reset_l,
  input  logic        start_h,
  input  logic        rd_rq_h,
  input  logic        wr_rq_h,
  input  logic [21:0] pa_h,
  input  logic        adr_par_h,
  input  logic [3:0]  word_rq_h,
  input  logic [35:0] wr_data_h,
  input  logic        wr_data_vld_h,
`ifdef SBUS_MEM_DATA_PAR_EN
  input  logic        wr_data_par_h,
  output logic        rd_data_par_h,
`endif
  output logic        start_ack_h,
  output logic [35:0] rd_data_h,
  output logic        rd_data_vld_h,
  output logic [1:0]  rd_word_h,
  output logic        busy_h,
  output logic        adr_par_err_h,
  output logic        nxm_err_h,
  output logic        data_par_err_h
);

`ifdef SBUS_MEM_DATA_PAR_EN
  localparam int DW = 37;
`else
  localparam int DW = 36;
`endif
  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_LIMIT  = MEM_WORDS;
  localparam logic [15:0] LAT_RELOAD = 16'(ACC_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_XFER
  } state_e;

  // With a single-cycle latency there is no wait between words.
  localparam state_e BURST_ENTRY = (ACC_LATENCY > 1) ? S_WAIT : S_XFER;

  // First requested word at or after 'from', searching upward mod 4.
  function automatic logic [1:0] first_word(input logic [1:0] from, input logic [3:0] mask);
    logic [1:0] w;
    first_word = from;
    for (int i = 3; i >= 0; i--) begin
      w = from + 2'(i);
      if (mask[w]) first_word = w;
    end
  endfunction

  state_e          state_q, state_d;
  logic [21:0]     pa_q, pa_d;
  logic            par_q, par_d;
  logic [3:0]      rem_q, rem_d;     // words of the burst still to be serviced
  logic            wr_q, wr_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            adr_err_q, adr_err_d;
  logic            nxm_err_q, nxm_err_d;
  logic [DW-1:0]   rd_data_q;
  logic            rd_vld_q;

  logic [DW-1:0]   mem_q [MEM_WORDS];
  logic            mem_we;
  logic            rd_load;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic [DW-1:0]   wr_word;
  logic [3:0]      rem_left;
  logic            pa_par_bad;
  logic            pa_nxm;

`ifdef SBUS_MEM_DATA_PAR_EN
  assign wr_word = {wr_data_par_h, wr_data_h};
`else
  assign wr_word = wr_data_h;
`endif

  assign rem_left   = rem_q & ~(4'b0001 << ptr_q);
  assign pa_par_bad = ~(^{pa_q, par_q});
  assign pa_nxm     = {10'd0, pa_q} >= MEM_LIMIT;
  assign wr_idx     = {pa_q[AW-1:2], ptr_q};
  assign rd_idx     = {pa_q[AW-1:2], ptr_d};

  // Next-state and burst sequencing.
  // NOTE: combinational logic uses blocking '=' and every variable gets a
  // default first, so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    pa_d      = pa_q;
    par_d     = par_q;
    rem_d     = rem_q;
    wr_d      = wr_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    adr_err_d = adr_err_q;
    nxm_err_d = nxm_err_q;
    mem_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_h && (rd_rq_h ^ wr_rq_h)) begin
          pa_d    = pa_h;
          par_d   = adr_par_h;
          rem_d   = word_rq_h;
          wr_d    = wr_rq_h;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (pa_par_bad) begin
          adr_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (pa_nxm) begin
          nxm_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (rem_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          ptr_d   = first_word(pa_q[1:0], rem_q);
          cnt_d   = LAT_RELOAD;
          state_d = BURST_ENTRY;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_d == 16'd0) state_d = S_XFER;
      end
      S_XFER: begin
        // Reads finish in one cycle; writes hold until the data is valid.
        if (!wr_q || wr_data_vld_h) begin
          mem_we = wr_q;
          rem_d  = rem_left;
          if (rem_left == 4'd0) begin
            state_d = S_IDLE;
          end else begin
            ptr_d   = first_word(ptr_q + 2'd1, rem_left);
            cnt_d   = LAT_RELOAD;
            state_d = BURST_ENTRY;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is fetched on the edge that enters XFER so it is registered.
  assign rd_load = (state_d == S_XFER) && !wr_q;

  // Control and output registers; reset aborts any burst in progress.
  always_ff @(posedge clk_mem_h or negedge mem_reset_l) begin
    if (!mem_reset_l) begin
      state_q   <= S_IDLE;
      pa_q      <= '0;
      par_q     <= 1'b0;
      rem_q     <= '0;
      wr_q      <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      adr_err_q <= 1'b0;
      nxm_err_q <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pa_q      <= pa_d;
      par_q     <= par_d;
      rem_q     <= rem_d;
      wr_q      <= wr_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      adr_err_q <= adr_err_d;
      nxm_err_q <= nxm_err_d;
      rd_vld_q  <= rd_load;
      if (rd_load) rd_data_q <= mem_q[rd_idx];
    end
  end

  // Word store write port.
  // NOTE: the store has no reset; reset forces IDLE, which holds mem_we low,
  // so a burst cut short by reset writes nothing further.
  always_ff @(posedge clk_mem_h) begin
    if (mem_we) mem_q[wr_idx] <= wr_word;
  end

`ifdef SBUS_MEM_DATA_PAR_EN
  logic dpar_err_q;

  // Sticky flag for written words whose data parity is even.
  always_ff @(posedge clk_mem_h or negedge mem_reset_l) begin
    if (!mem_reset_l)                           dpar_err_q <= 1'b0;
    else if (mem_we && !(^wr_word))             dpar_err_q <= 1'b1;
  end

  assign data_par_err_h = dpar_err_q;
  assign rd_data_par_h  = rd_data_q[36];
  assign rd_data_h      = rd_data_q[35:0];
`else
  assign data_par_err_h = 1'b0;
  assign rd_data_h      = rd_data_q;
`endif

  assign start_ack_h   = (state_q == S_CHECK);
  assign busy_h        = (state_q != S_IDLE);
  assign rd_data_vld_h = rd_vld_q;
  assign rd_word_h     = ((state_q == S_XFER) && (!wr_q || wr_data_vld_h)) ? ptr_q : 2'd0;
  assign adr_par_err_h = adr_err_q;
  assign nxm_err_h     = nxm_err_q;

endmodule

// File: tb/tb_sbus_mem_responder.sv
// Bench for sbus_mem_responder. Expected read words are pushed to a
// scoreboard when a request is issued. A negedge monitor pops each one on
// rd_data_vld_h and compares data, word number and arrival cycle.
module tb_sbus_mem_responder;
  localparam int MEM_WORDS   = 4096;
  localparam int ACC_LATENCY = 2;

  logic        clk = 1'b0;
  logic        mem_reset_l = 1'b1;
  logic        start_h = 1'b0, rd_rq_h = 1'b0, wr_rq_h = 1'b0;
  logic [21:0] pa_h = '0;
  logic        adr_par_h = 1'b0;
  logic [3:0]  word_rq_h = '0;
  logic [35:0] wr_data_h = '0;
  logic        wr_data_vld_h = 1'b0;
  logic        start_ack_h, rd_data_vld_h, busy_h;
  logic [35:0] rd_data_h;
  logic [1:0]  rd_word_h;
  logic        adr_par_err_h, nxm_err_h, data_par_err_h;
`ifdef SBUS_MEM_DATA_PAR_EN
  logic        wr_data_par_h = 1'b0;
  logic        rd_data_par_h;
  logic        wr_par_flip = 1'b0;
  logic        model_par [int];
`endif

  sbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .ACC_LATENCY(ACC_LATENCY)) dut (
    .clk_mem_h     (clk),
    .mem_reset_l   (mem_reset_l),
    .start_h       (start_h),
    .rd_rq_h       (rd_rq_h),
    .wr_rq_h       (wr_rq_h),
    .pa_h          (pa_h),
    .adr_par_h     (adr_par_h),
    .word_rq_h     (word_rq_h),
    .wr_data_h     (wr_data_h),
    .wr_data_vld_h (wr_data_vld_h),
`ifdef SBUS_MEM_DATA_PAR_EN
    .wr_data_par_h (wr_data_par_h),
    .rd_data_par_h (rd_data_par_h),
`endif
    .start_ack_h   (start_ack_h),
    .rd_data_h     (rd_data_h),
    .rd_data_vld_h (rd_data_vld_h),
    .rd_word_h     (rd_word_h),
    .busy_h        (busy_h),
    .adr_par_err_h (adr_par_err_h),
    .nxm_err_h     (nxm_err_h),
    .data_par_err_h(data_par_err_h)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  word;
    logic [35:0] data;
`ifdef SBUS_MEM_DATA_PAR_EN
    logic        par;
`endif
    int          cyc;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        mon_e;
  logic [35:0] model [int];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          vld_seen = 0;
  int          c0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-data monitor: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rd_data_vld_h === 1'b1) begin
      logic par_bad;
      vld_seen++;
      total_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL rd_strobe: unexpected word=%0d data=%o at cycle %0d, required no strobe",
                 rd_word_h, rd_data_h, cyc);
      end else begin
        mon_e   = sb_q.pop_front();
        par_bad = 1'b0;
`ifdef SBUS_MEM_DATA_PAR_EN
        par_bad = (rd_data_par_h !== mon_e.par);
`endif
        if (rd_data_h !== mon_e.data || rd_word_h !== mon_e.word || cyc != mon_e.cyc || par_bad)
          $display("FAIL rd_data: got word=%0d data=%o cycle=%0d, required word=%0d data=%o cycle=%0d",
                   rd_word_h, rd_data_h, cyc, mon_e.word, mon_e.data, mon_e.cyc);
        else
          pass_cnt++;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Drive one start strobe at a negedge; returns one cycle later (ack cycle).
  task automatic issue(input logic [21:0] pa, input logic par, input logic rd,
                       input logic wr, input logic [3:0] mask);
    c0 = cyc;
    start_h = 1'b1; rd_rq_h = rd; wr_rq_h = wr;
    pa_h = pa; adr_par_h = par; word_rq_h = mask;
    @(negedge clk);
    start_h = 1'b0; rd_rq_h = 1'b0; wr_rq_h = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while (busy_h !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (busy_h !== 1'b0) $display("FAIL %s: busy_h=%b after %0d cycles, required 0", name, busy_h, n);
    else pass_cnt++;
  endtask

  // Queue the words a read of (pa, mask) issued at cycle c_start must return.
  task automatic expect_read(input logic [21:0] pa, input logic [3:0] mask, input int c_start);
    int t;
    logic [1:0] w;
    exp_t e;
    t = c_start + 1 + ACC_LATENCY;
    for (int i = 0; i < 4; i++) begin
      w = pa[1:0] + 2'(i);
      if (mask[w]) begin
        e.word = w;
        e.data = model[int'({pa[21:2], w})];
`ifdef SBUS_MEM_DATA_PAR_EN
        e.par  = model_par[int'({pa[21:2], w})];
`endif
        e.cyc  = t;
        sb_q.push_back(e);
        t += ACC_LATENCY;
      end
    end
  endtask

  task automatic read_burst(input logic [21:0] pa, input logic [3:0] mask, output int idle_rel);
    expect_read(pa, mask, cyc);
    issue(pa, ~^pa, 1'b1, 1'b0, mask);
    total_cnt++;
    if (start_ack_h !== 1'b1) $display("FAIL read_ack: start_ack_h=%b, required 1", start_ack_h);
    else pass_cnt++;
    wait_idle(16 * ACC_LATENCY + 16, "read_idle");
    idle_rel = cyc - c0;
    total_cnt++;
    if (sb_q.size() != 0) begin
      $display("FAIL read_words: %0d words not returned, required 0", sb_q.size());
      sb_q.delete();
    end else pass_cnt++;
  endtask

  // Supply write data in each expected XFER cycle; 'hold' delays the first word.
  task automatic write_burst(input logic [21:0] pa, input logic [3:0] mask,
                             input logic [35:0] data [4], input int hold);
    int t;
    logic [1:0] w;
    issue(pa, ~^pa, 1'b0, 1'b1, mask);
    total_cnt++;
    if (start_ack_h !== 1'b1) $display("FAIL write_ack: start_ack_h=%b, required 1", start_ack_h);
    else pass_cnt++;
    t = c0 + 1 + ACC_LATENCY + hold;
    for (int i = 0; i < 4; i++) begin
      w = pa[1:0] + 2'(i);
      if (mask[w]) begin
        while (cyc < t) @(negedge clk);
        wr_data_h = data[w];
        wr_data_vld_h = 1'b1;
`ifdef SBUS_MEM_DATA_PAR_EN
        wr_data_par_h = ~^data[w] ^ wr_par_flip;
        model_par[int'({pa[21:2], w})] = ~^data[w] ^ wr_par_flip;
`endif
        #1;
        total_cnt++;
        if (rd_word_h !== w) $display("FAIL write_word: rd_word_h=%0d, required %0d", rd_word_h, w);
        else pass_cnt++;
        model[int'({pa[21:2], w})] = data[w];
        @(negedge clk);
        wr_data_vld_h = 1'b0;
        t = cyc - 1 + ACC_LATENCY;
      end
    end
    wait_idle(16 * ACC_LATENCY + 16, "write_idle");
  endtask

  task automatic test_reset();
    #2 mem_reset_l = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({start_ack_h, rd_data_vld_h, rd_word_h, busy_h, adr_par_err_h, nxm_err_h,
         data_par_err_h, rd_data_h} !== '0)
      $display("FAIL reset_outputs: busy=%b vld=%b data=%o, required all 0", busy_h, rd_data_vld_h, rd_data_h);
    else pass_cnt++;
    mem_reset_l = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({start_ack_h, rd_data_vld_h, busy_h, adr_par_err_h, nxm_err_h, data_par_err_h} !== '0)
      $display("FAIL post_reset_idle: ack=%b busy=%b, required 0", start_ack_h, busy_h);
    else pass_cnt++;
  endtask

  task automatic test_write();
    logic [35:0] d [4];
    int rel;
    d = '{36'o111, 36'o222, 36'o333, 36'o444};
    write_burst(22'o000010, 4'b1111, d, 0);
    d = '{36'o123, 36'o777, 36'o456, 36'o777};
    write_burst(22'o000010, 4'b0101, d, 0);
    read_burst(22'o000010, 4'b1111, rel);
  endtask

  task automatic test_read_burst();
    logic [35:0] d [4];
    int rel;
    d = '{36'o700000000001, 36'o012345670123, 36'o525252525252, 36'o252525252525};
    write_burst(22'o000100, 4'b1111, d, 2);
    read_burst(22'o000101, 4'b1111, rel);
    total_cnt++;
    if (rel != 2 + 4 * ACC_LATENCY)
      $display("FAIL read_busy_drop: busy_h fell at start+%0d, required start+%0d", rel, 2 + 4 * ACC_LATENCY);
    else pass_cnt++;
  endtask

  task automatic test_adr_parity();
    int vb, rel;
    vb = vld_seen;
    issue(22'o000200, ^22'o000200, 1'b1, 1'b0, 4'b1111);
    total_cnt++;
    if (start_ack_h !== 1'b1) $display("FAIL par_ack: start_ack_h=%b, required 1", start_ack_h);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (adr_par_err_h !== 1'b1 || busy_h !== 1'b0 || nxm_err_h !== 1'b0)
      $display("FAIL par_err: adr_par_err_h=%b busy_h=%b nxm=%b, required 1 0 0", adr_par_err_h, busy_h, nxm_err_h);
    else pass_cnt++;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (vld_seen != vb) $display("FAIL par_no_data: %0d strobes, required 0", vld_seen - vb);
    else pass_cnt++;
    read_burst(22'o000102, 4'b0011, rel);
  endtask

  task automatic test_nxm();
    logic [35:0] d [4];
    int vb, rel;
    vb = vld_seen;
    issue(22'(MEM_WORDS), ~^22'(MEM_WORDS), 1'b1, 1'b0, 4'b1111);
    total_cnt++;
    if (start_ack_h !== 1'b1) $display("FAIL nxm_ack: start_ack_h=%b, required 1", start_ack_h);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (nxm_err_h !== 1'b1 || busy_h !== 1'b0)
      $display("FAIL nxm_err: nxm_err_h=%b busy_h=%b, required 1 0", nxm_err_h, busy_h);
    else pass_cnt++;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (vld_seen != vb) $display("FAIL nxm_no_data: %0d strobes, required 0", vld_seen - vb);
    else pass_cnt++;
    d = '{36'o0, 36'o0, 36'o0, 36'o765432107654};
    write_burst(22'(MEM_WORDS - 1), 4'b1000, d, 0);
    vb = vld_seen;
    read_burst(22'(MEM_WORDS - 1), 4'b1000, rel);
    total_cnt++;
    if (vld_seen - vb != 1) $display("FAIL top_word_count: %0d strobes, required 1", vld_seen - vb);
    else pass_cnt++;
  endtask

  task automatic test_ignore();
    issue(22'o000100, ~^22'o000100, 1'b1, 1'b1, 4'b1111);
    total_cnt++;
    if (start_ack_h !== 1'b0 || busy_h !== 1'b0)
      $display("FAIL both_types: ack=%b busy=%b, required 0 0", start_ack_h, busy_h);
    else pass_cnt++;
    issue(22'o000100, ~^22'o000100, 1'b0, 1'b0, 4'b1111);
    total_cnt++;
    if (start_ack_h !== 1'b0 || busy_h !== 1'b0)
      $display("FAIL no_type: ack=%b busy=%b, required 0 0", start_ack_h, busy_h);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    expect_read(22'o000102, 4'b0100, cyc);
    issue(22'o000102, ~^22'o000102, 1'b1, 1'b0, 4'b0100);
    total_cnt++;
    if (start_ack_h !== 1'b1) $display("FAIL b2b_ack1: start_ack_h=%b, required 1", start_ack_h);
    else pass_cnt++;
    // A write start while busy must be ignored.
    start_h = 1'b1; wr_rq_h = 1'b1; pa_h = 22'o000300; adr_par_h = ~^22'o000300; word_rq_h = 4'b1111;
    repeat (2) @(negedge clk);
    // Last XFER cycle: this read start is only taken on the following cycle.
    wr_rq_h = 1'b0; rd_rq_h = 1'b1; pa_h = 22'o000101; adr_par_h = ~^22'o000101; word_rq_h = 4'b0001;
    expect_read(22'o000101, 4'b0001, cyc + 1);
    @(negedge clk);
    total_cnt++;
    if (start_ack_h !== 1'b0 || busy_h !== 1'b0)
      $display("FAIL b2b_end_cycle: ack=%b busy=%b, required 0 0", start_ack_h, busy_h);
    else pass_cnt++;
    @(negedge clk);
    start_h = 1'b0; rd_rq_h = 1'b0;
    total_cnt++;
    if (start_ack_h !== 1'b1) $display("FAIL b2b_ack2: start_ack_h=%b, required 1", start_ack_h);
    else pass_cnt++;
    wait_idle(32, "b2b_idle");
    total_cnt++;
    if (sb_q.size() != 0) begin
      $display("FAIL b2b_words: %0d words not returned, required 0", sb_q.size());
      sb_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    int cs, vb, rel;
    cs = cyc;
    vb = vld_seen;
    expect_read(22'o000100, 4'b1111, cs);
    issue(22'o000100, ~^22'o000100, 1'b1, 1'b0, 4'b1111);
    while (cyc < cs + 1 + 2 * ACC_LATENCY) @(negedge clk);
    #2 mem_reset_l = 1'b0;
    #1;
    total_cnt++;
    if ({start_ack_h, rd_data_vld_h, rd_word_h, busy_h, adr_par_err_h, nxm_err_h,
         data_par_err_h, rd_data_h} !== '0)
      $display("FAIL abort_outputs: busy=%b vld=%b word=%0d data=%o, required all 0",
               busy_h, rd_data_vld_h, rd_word_h, rd_data_h);
    else pass_cnt++;
    total_cnt++;
    if (vld_seen - vb != 2) $display("FAIL abort_words_before: %0d strobes, required 2", vld_seen - vb);
    else pass_cnt++;
    sb_q.delete();
    repeat (2) @(negedge clk);
    mem_reset_l = 1'b1;
    vb = vld_seen;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy_h !== 1'b0 || vld_seen != vb)
      $display("FAIL abort_idle: busy=%b strobes=%0d, required 0 0", busy_h, vld_seen - vb);
    else pass_cnt++;
    read_burst(22'o000100, 4'b1111, rel);
  endtask

`ifdef SBUS_MEM_DATA_PAR_EN
  task automatic test_data_parity();
    logic [35:0] d [4];
    int rel;
    d = '{36'o246, 36'o0, 36'o0, 36'o0};
    wr_par_flip = 1'b1;
    write_burst(22'o000300, 4'b0001, d, 0);
    wr_par_flip = 1'b0;
    total_cnt++;
    if (data_par_err_h !== 1'b1) $display("FAIL data_par_err: data_par_err_h=%b, required 1", data_par_err_h);
    else pass_cnt++;
    read_burst(22'o000300, 4'b0001, rel);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_burst();
    test_adr_parity();
    test_nxm();
    test_ignore();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef SBUS_MEM_DATA_PAR_EN
    test_data_parity();
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
